// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit segment scan path.
// Segment patterns are active-low [0:6]; enables are active-low one-hot {o4,o3,o2,o1}.
package seg_pkg;

  localparam int DIGIT_COUNT = 4;

  typedef logic [0:6] seg_t;
  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] dig_en_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b1111110;

  localparam dig_en_t EN_D1   = 4'b1110;
  localparam dig_en_t EN_D2   = 4'b1101;
  localparam dig_en_t EN_D3   = 4'b1011;
  localparam dig_en_t EN_D4   = 4'b0111;
  localparam dig_en_t EN_NONE = 4'b1111;

  function automatic dig_en_t digit_enable(input digit_idx_t idx);
    dig_en_t en;
    case (idx)
      2'd0:    en = EN_D1;
      2'd1:    en = EN_D2;
      2'd2:    en = EN_D3;
      default: en = EN_D4;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: cnt counts 0..SCAN_DIV-1 per digit slot, idx steps digits 0..3 on wrap.
// Phase/snapshot strobe are combinational from state; free-running, no backpressure.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  output phase_e     phase_o,
  output digit_idx_t idx_o,
  output logic [1:0] cnt_lsb_o,
  output logic       snap_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = wrap ? digit_idx_t'(idx_q + 2'd1) : idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign phase_o   = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
  assign idx_o     = idx_q;
  assign cnt_lsb_o = cnt_q[1:0];
  // Frame start: first cycle of digit 1, always inside the blank window.
  assign snap_o    = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit segment scanner: per-frame tear-free snapshot, blanked digit slots; outputs 1-cycle registered.
// No backpressure (inputs sampled at frame start); SEG_DIM_EN adds dim[1:0] duty control within DRIVE.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEG_DIM_EN
  input  logic [1:0] dim,
`endif
  input  logic [0:6] b1,
  input  logic [0:6] b2,
  input  logic [0:6] b3,
  input  logic [0:6] b4,
  output logic [0:6] bcd,
  output logic       o1,
  output logic       o2,
  output logic       o3,
  output logic       o4,
  output logic       frame_tick
);

  phase_e     phase;
  digit_idx_t idx;
  logic [1:0] cnt_lsb;
  logic       snap;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .phase_o   (phase),
    .idx_o     (idx),
    .cnt_lsb_o (cnt_lsb),
    .snap_o    (snap)
  );

  seg_t    b_in [DIGIT_COUNT];
  seg_t    sh_q [DIGIT_COUNT];
  seg_t    sh_d [DIGIT_COUNT];
  seg_t    bcd_q, bcd_d;
  dig_en_t en_q, en_d;
  logic    tick_q, tick_d;
  logic    drive;

  assign b_in[0] = b1;
  assign b_in[1] = b2;
  assign b_in[2] = b3;
  assign b_in[3] = b4;

`ifndef SEG_DIM_EN
  logic cnt_lsb_unused;
  assign cnt_lsb_unused = ^cnt_lsb;
`endif

  always_comb begin
    drive = (phase == PH_DRIVE);
`ifdef SEG_DIM_EN
    // Dimming gates the enable on the low counter bits, so duty is (dim+1)/4.
    drive = drive && (cnt_lsb <= dim);
`endif
    en_d   = drive ? digit_enable(idx) : EN_NONE;
    bcd_d  = drive ? sh_q[idx] : SEG_BLANK;
    tick_d = snap;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      sh_d[i] = snap ? b_in[i] : sh_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGIT_COUNT; i++) begin
        sh_q[i] <= SEG_BLANK;
      end
      bcd_q  <= SEG_BLANK;
      en_q   <= EN_NONE;
      tick_q <= 1'b0;
    end else begin
      for (int i = 0; i < DIGIT_COUNT; i++) begin
        sh_q[i] <= sh_d[i];
      end
      bcd_q  <= bcd_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign {o4, o3, o2, o1} = en_q;
  assign bcd              = bcd_q;
  assign frame_tick       = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at SCAN_DIV=8: instance A with BLANK_CYCLES=2, instance B with BLANK_CYCLES=7.
// Outputs sampled on the falling edge; k counts rising edges since reset release.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:6] b1, b2, b3, b4;
  logic [0:6] bcd_a, bcd_b;
  logic       o1_a, o2_a, o3_a, o4_a, tick_a;
  logic       o1_b, o2_b, o3_b, o4_b, tick_b;
`ifdef SEG_DIM_EN
  logic [1:0] dim = 2'd3;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int k        = 0;
  logic [0:6] exp_sh [4];

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
`ifdef SEG_DIM_EN
    .dim(dim),
`endif
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .bcd(bcd_a), .o1(o1_a), .o2(o2_a), .o3(o3_a), .o4(o4_a), .frame_tick(tick_a)
  );

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(7)) dut_b (
    .clk(clk), .rst(rst),
`ifdef SEG_DIM_EN
    .dim(dim),
`endif
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .bcd(bcd_b), .o1(o1_b), .o2(o2_b), .o3(o3_b), .o4(o4_b), .frame_tick(tick_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the next falling edge and compare both instances to the scan model.
  task automatic step_and_check();
    int c, s;
    logic [3:0] en_a, en_b;
    logic [0:6] bx_a, bx_b;
    @(negedge clk);
    k++;
    c = (k - 1) % 8;
    s = ((k - 1) / 8) % 4;
    if ((k - 1) % 32 == 0) begin
      exp_sh[0] = b1; exp_sh[1] = b2; exp_sh[2] = b3; exp_sh[3] = b4;
    end
    en_a = (c >= 2) ? ~(4'b0001 << s) : 4'b1111;
    bx_a = (c >= 2) ? exp_sh[s] : 7'b1111111;
    en_b = (c == 7) ? ~(4'b0001 << s) : 4'b1111;
    bx_b = (c == 7) ? exp_sh[s] : 7'b1111111;
    check("en_a",   32'({o4_a, o3_a, o2_a, o1_a}), 32'(en_a));
    check("bcd_a",  32'(bcd_a), 32'(bx_a));
    check("tick_a", 32'(tick_a), 32'((k - 1) % 32 == 0));
    check("onehot_a", 32'($countones(~{o4_a, o3_a, o2_a, o1_a}) <= 1), 32'd1);
    check("en_b",   32'({o4_b, o3_b, o2_b, o1_b}), 32'(en_b));
    check("bcd_b",  32'(bcd_b), 32'(bx_b));
    check("tick_b", 32'(tick_b), 32'((k - 1) % 32 == 0));
  endtask

  task automatic run(input int n, input bit rand_b);
    repeat (n) begin
      if (rand_b && $urandom_range(3) == 0) begin
        b1 = 7'($urandom); b2 = 7'($urandom); b3 = 7'($urandom); b4 = 7'($urandom);
      end
      step_and_check();
    end
  endtask

  initial begin
    b1 = 7'b1001111; b2 = 7'b0010010; b3 = 7'b0000110; b4 = 7'b1001100;
    for (int i = 0; i < 4; i++) exp_sh[i] = 7'b1111111;

    #12;
    check("rst_en_a",   32'({o4_a, o3_a, o2_a, o1_a}), 32'(4'b1111));
    check("rst_bcd_a",  32'(bcd_a), 32'(7'b1111111));
    check("rst_tick_a", 32'(tick_a), 32'd0);
    check("rst_en_b",   32'({o4_b, o3_b, o2_b, o1_b}), 32'(4'b1111));

    @(negedge clk);
    rst = 1'b1;

    run(1, 0);
    check("first_tick", 32'(tick_a), 32'd1);
    run(1, 0);
    check("second_no_tick", 32'(tick_a), 32'd0);
    run(1, 0);
    check("f1_d1", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1110, 7'b1001111}));
    run(8, 0);
    check("f1_d2", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1101, 7'b0010010}));
    run(22, 0);
    check("period_tick", 32'(tick_a), 32'd1);

    // k=33 here; digit 2 of frame 2 is driven at k=43..48.
    run(11, 0);
    check("d2_active", 32'({o4_a, o3_a, o2_a, o1_a}), 32'(4'b1101));
    b3 = 7'b0000000;
    run(7, 0);
    check("b3_stale", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1011, 7'b0000110}));
    run(32, 0);
    check("b3_fresh", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1011, 7'b0000000}));

    run(32 * 1000, 1);

    // Park mid-DRIVE of digit 3 (slot 2, cnt 4), then assert reset between edges.
    for (int i = 0; i < 32 && ((k - 1) % 32) != 20; i++) step_and_check();
    check("pre_rst_d3", 32'({o4_a, o3_a, o2_a, o1_a}), 32'(4'b1011));
    #2 rst = 1'b0;
    #1;
    check("arst_en_a",   32'({o4_a, o3_a, o2_a, o1_a}), 32'(4'b1111));
    check("arst_bcd_a",  32'(bcd_a), 32'(7'b1111111));
    check("arst_tick_a", 32'(tick_a), 32'd0);
    check("arst_en_b",   32'({o4_b, o3_b, o2_b, o1_b}), 32'(4'b1111));
    b1 = 7'b0100100; b2 = 7'b0110000; b3 = 7'b0011001; b4 = 7'b0010010;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    run(3, 0);
    check("rst_d1", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1110, 7'b0100100}));
    run(9, 0);
    check("rst_d2", 32'({o4_a, o3_a, o2_a, o1_a, bcd_a}), 32'({4'b1101, 7'b0110000}));
    run(64, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Consumer end of the four-digit segment interface. Front-panel controllers produce four 7-bit segment patterns, b1..b4, with digit order 4321 (b1 is the rightmost digit). This block time-multiplexes those patterns onto the shared segment bus bcd and the digit enables o1..o4. It takes a tear-free snapshot once per frame and inserts a blanking interval between digits to suppress ghosting.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..2^20.
BLANK_CYCLES, 500, blank cycles at the start of each slot; must satisfy 1 <= BLANK_CYCLES < SCAN_DIV.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
b1  in  [0:6]  segment pattern, digit 1 (rightmost); active-low segments, 7'b1111111 = blank.
b2  in  [0:6]  segment pattern, digit 2.
b3  in  [0:6]  segment pattern, digit 3.
b4  in  [0:6]  segment pattern, digit 4 (leftmost).
bcd  out  [0:6]  shared segment bus, active-low, registered.
o1  out  1  digit-1 enable, active-low, registered.
o2  out  1  digit-2 enable, active-low, registered.
o3  out  1  digit-3 enable, active-low, registered.
o4  out  1  digit-4 enable, active-low, registered.
frame_tick  out  1  one-cycle pulse, registered; marks the snapshot edge.

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt=0, idx=0.
  - Shadow registers sh1..sh4 = 7'b1111111.
  - bcd=7'b1111111, o1..o4=1, frame_tick=0.
- Slot counter: cnt runs 0..SCAN_DIV-1. At SCAN_DIV-1, cnt wraps to 0 and idx advances 0->1->2->3->0. Scan order is digit1, 2, 3, 4.
- Phase is combinational from the counter: BLANK when cnt < BLANK_CYCLES, DRIVE otherwise.
- Snapshot: on every edge where idx==0 and cnt==0, sh1..sh4 <= b1..b4. frame_tick is registered high for exactly that following cycle.
  - The first edge after reset release is a snapshot edge.
  - Input changes between snapshots have no effect until the next frame; no tearing within a frame.
- Outputs, registered with 1-cycle latency from the (cnt, idx) state:
  - In DRIVE: the selected o(idx+1) = 0, the other enables = 1, bcd = sh(idx+1).
  - In BLANK: all enables = 1 and bcd = 7'b1111111.
- Invariant: at most one enable is low in any cycle. Enables never overlap across a digit change; at least BLANK_CYCLES cycles separate them.
- Frame period = 4*SCAN_DIV cycles. Each digit is driven for SCAN_DIV-BLANK_CYCLES cycles per frame.
- Reset mid-frame: outputs go blank immediately (asynchronously). Scanning restarts at digit1 with a fresh snapshot on the first edge after release.
- No handshake back to producers. Producers may change b1..b4 on any cycle.

Optional Feature:
Macro SEG_DIM_EN.
- When defined: adds input dim [1:0]. In DRIVE, the selected enable is asserted only when cnt[1:0] <= dim, otherwise all enables = 1 and bcd = blank.
  - dim=3 gives full duty; dim=0 gives 25% duty.
  - dim is sampled every cycle, not snapshotted.
- When undefined: no dim port, and full duty throughout DRIVE.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b1111110.
  - The 2-bit digit-index type.
  - Active-low one-hot enable constants EN_D1..EN_D4 (4'b1110..4'b0111 for {o4,o3,o2,o1}).
  - DIGIT_COUNT=4.
- One natural sub-module, seg_scan_timer: owns cnt/idx and emits phase, idx and snapshot strobe. The top instantiates it and holds the shadow and output registers.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless stated):
- Reset then release with b1..b4 = 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100 -> frame_tick high one cycle after first edge; cycles 3..8 show o1=0 with bcd=7'b1001111; then o2 with 7'b0010010, then o3, then o4; period 32 cycles.
- Overlap check over 1000 frames with random b inputs -> never more than one of o1..o4 low; at least 2 cycles with all enables high at each digit change.
- Change b3 to 7'b0000000 while o2 is active -> o3 still shows the old value this frame; the new value appears only after the next frame_tick.
- Assert rst=0 mid-DRIVE of digit 3 -> same-cycle asynchronous blank (o1..o4=1, bcd=7'b1111111); after release, scan restarts at digit1 with a new snapshot.
- SEG_DIM_EN defined, dim=0 -> within each DRIVE phase the enable is low only where cnt[1:0]==0; dim=3 -> identical to the build without the macro.
- BLANK_CYCLES=SCAN_DIV-1 -> each digit is driven exactly 1 cycle per slot; no overlap; values correct.
